// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regfile_arb_pkg;
  localparam int DEF_ADDR_WIDTH = 2;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic {ST_INIT, ST_ARB} state_e;
  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_idx_e;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes and register-file write port of the write arbiter.
interface regfile_write_arbiter_if
  import regfile_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic                  io_a_req;
  logic [ADDR_WIDTH-1:0] io_a_addr;
  logic [DATA_WIDTH-1:0] io_a_din;
  logic                  io_a_ack;
  logic                  io_b_req;
  logic [ADDR_WIDTH-1:0] io_b_addr;
  logic [DATA_WIDTH-1:0] io_b_din;
  logic                  io_b_ack;
  logic                  io_mem_wr;
  logic [ADDR_WIDTH-1:0] io_mem_addr;
  logic [DATA_WIDTH-1:0] io_mem_din;
  logic                  io_busy;

  modport master (
    output io_a_req, io_a_addr, io_a_din, io_b_req, io_b_addr, io_b_din,
    input  io_a_ack, io_b_ack, io_mem_wr, io_mem_addr, io_mem_din, io_busy
  );

  modport slave (
    input  io_a_req, io_a_addr, io_a_din, io_b_req, io_b_addr, io_b_din,
    output io_a_ack, io_b_ack, io_mem_wr, io_mem_addr, io_mem_din, io_busy
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; pointer breaks ties only.
module rr_pick2
  import regfile_arb_pkg::*;
(
  input  logic [1:0] eligible,
  input  req_idx_e   pointer,
  output logic       grant_valid,
  output req_idx_e   grant_idx
);
  always_comb begin
    grant_valid = |eligible;
    if (&eligible)       grant_idx = pointer;
    else if (eligible[1]) grant_idx = REQ_B;
    else                 grant_idx = REQ_A;
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin owner of the register-file write port, one registered write per cycle.
// REGFILE_ARB_INIT_EN adds a post-reset sweep writing INIT_VALUE to every register.
module regfile_write_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic                     clock,
  input logic                     reset,
  regfile_write_arbiter_if.slave  bus
);
  logic [1:0]            eligible;
  logic                  grant_valid;
  req_idx_e              grant_idx;
  req_idx_e              ptr_q, ptr_d;
  logic                  arb_en;
  logic                  wr_d, a_ack_d, b_ack_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;

`ifdef REGFILE_ARB_INIT_EN
  localparam int                    NUM_REGS  = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   INIT_DONE = (ADDR_WIDTH+1)'(NUM_REGS);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
  logic                  busy_d;
`else
  logic unused_init;
  assign unused_init = ^INIT_VALUE;
  assign bus.io_busy = 1'b0;
`endif

  // A requester acked this cycle may still be holding req; skip it once.
  assign eligible = {bus.io_b_req & ~bus.io_b_ack, bus.io_a_req & ~bus.io_a_ack};

  rr_pick2 u_pick (
    .eligible    (eligible),
    .pointer     (ptr_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  always_comb begin
    wr_d    = 1'b0;
    a_ack_d = 1'b0;
    b_ack_d = 1'b0;
    addr_d  = bus.io_mem_addr;
    din_d   = bus.io_mem_din;
    ptr_d   = ptr_q;
`ifdef REGFILE_ARB_INIT_EN
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    busy_d     = bus.io_busy;
    arb_en     = 1'b0;
    case (state_q)
      ST_INIT: begin
        // Counter is one bit wider so the exit test sees NUM_REGS, not a wrap.
        if (init_cnt_q == INIT_DONE) begin
          state_d = ST_ARB;
          busy_d  = 1'b0;
        end else begin
          wr_d       = 1'b1;
          addr_d     = init_cnt_q[ADDR_WIDTH-1:0];
          din_d      = INIT_VALUE;
          init_cnt_d = init_cnt_q + (ADDR_WIDTH+1)'(1);
        end
      end
      ST_ARB: arb_en = 1'b1;
    endcase
`else
    arb_en = 1'b1;
`endif
    if (arb_en && grant_valid) begin
      wr_d    = 1'b1;
      a_ack_d = (grant_idx == REQ_A);
      b_ack_d = (grant_idx == REQ_B);
      addr_d  = (grant_idx == REQ_B) ? bus.io_b_addr : bus.io_a_addr;
      din_d   = (grant_idx == REQ_B) ? bus.io_b_din  : bus.io_a_din;
      ptr_d   = (grant_idx == REQ_A) ? REQ_B : REQ_A;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.io_mem_wr   <= 1'b0;
      bus.io_mem_addr <= '0;
      bus.io_mem_din  <= '0;
      bus.io_a_ack    <= 1'b0;
      bus.io_b_ack    <= 1'b0;
      ptr_q           <= REQ_A;
`ifdef REGFILE_ARB_INIT_EN
      state_q         <= ST_INIT;
      init_cnt_q      <= '0;
      bus.io_busy     <= 1'b1;
`endif
    end else begin
      bus.io_mem_wr   <= wr_d;
      bus.io_mem_addr <= addr_d;
      bus.io_mem_din  <= din_d;
      bus.io_a_ack    <= a_ack_d;
      bus.io_b_ack    <= b_ack_d;
      ptr_q           <= ptr_d;
`ifdef REGFILE_ARB_INIT_EN
      state_q         <= state_d;
      init_cnt_q      <= init_cnt_d;
      bus.io_busy     <= busy_d;
`endif
    end
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Owns the single write port of the 4-entry, 16-bit video/config register file and shares it between two requesters.
  - Requester A: CPU bus bridge.
  - Requester B: DMA/config loader.
- After reset it runs an init sequence that writes a known value to every register.
- It then grants one write per cycle using round-robin arbitration with a req/ack handshake.
- Sits between the bus decoders and the register file, whose port is mem_wr/mem_addr/mem_din.

Parameters:
- ADDR_WIDTH, 2, register address width; NUM_REGS = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, register data width.
- INIT_VALUE, 16'h0000, value written to every register during init.

Ports:
- clock  in  1  system clock; one clock, all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- io_a_req  in  1  requester A write request; held until acked.
- io_a_addr  in  ADDR_WIDTH  A target register.
- io_a_din  in  DATA_WIDTH  A write data.
- io_a_ack  out  1  one-cycle pulse; A's write is on the mem port this cycle.
- io_b_req / io_b_addr / io_b_din / io_b_ack  same as A, for requester B.
- io_mem_wr  out  1  register file write enable.
- io_mem_addr  out  ADDR_WIDTH  register file address.
- io_mem_din  out  DATA_WIDTH  register file write data.
- io_busy  out  1  high while the init sequence runs.

Behaviour:
- All outputs are registered.
- Reset values: io_mem_wr=0, io_mem_addr=0, io_mem_din=0, io_a_ack=0, io_b_ack=0, io_busy=1.
- Reset puts the FSM in INIT, sets init_cnt=0 and sets the round-robin pointer to prefer A.
- Handshake:
  - A requester drives req=1 with addr/din stable until it samples ack=1.
  - ack lasts exactly one cycle and coincides with io_mem_wr=1 carrying that requester's addr/din.
  - The requester may drop req, or present a new request, in the cycle after ack.
- Latency: a request sampled in cycle t is presented on the mem port with ack in cycle t+1.
- Eligibility: a requester whose ack is high in the current cycle is ineligible this cycle. This prevents a double grant of a still-held request. A lone requester therefore gets at most one write every 2 cycles.
- FSM INIT:
  - Each cycle: io_mem_wr=1, io_mem_addr=init_cnt, io_mem_din=INIT_VALUE, then init_cnt++.
  - After the write of NUM_REGS-1 has been presented, go to ARB.
  - io_busy=0 from the first ARB cycle.
  - Requests are not acked during INIT; they stay pending.
- FSM ARB:
  - No eligible request: io_mem_wr=0; addr/din hold their last values; acks 0.
  - One eligible request: grant it.
  - Both eligible: grant the one not granted most recently; the pointer toggles to the other requester after each grant.
  - A lone-requester grant also updates the pointer.
- Simultaneous requests to the same address are serialised in arbitration order; the last write wins.
- init_cnt wraps are not used: the counter is ADDR_WIDTH+1 bits wide and the FSM exits on terminal count.
- Reset asserted mid-operation: takes effect at the next edge; acks and io_mem_wr go 0, any in-flight grant is dropped, and INIT restarts from address 0.
- ARB never returns to INIT except via reset.

Optional Feature:
- Macro: REGFILE_ARB_INIT_EN.
- Defined: INIT sequence as above; io_busy=1 out of reset.
- Undefined:
  - No INIT state; the FSM enters ARB directly out of reset.
  - io_busy is tied 0.
  - The INIT_VALUE parameter is unused and init_cnt is not built.

Decomposition:
- Package regfile_arb_pkg holds:
  - state enum: ST_INIT, ST_ARB;
  - requester index typedef: REQ_A=0, REQ_B=1;
  - default ADDR_WIDTH/DATA_WIDTH constants.
- One sub-module, rr_pick2: a combinational two-way round-robin picker.
  - Inputs: eligible[1:0], pointer.
  - Outputs: grant_valid, grant_idx.
- The FSM, counter, output registers and pointer stay in the top.

Test Plan:
- Reset release (INIT_EN): cycles 1-4 show io_mem_wr=1 with addr 0,1,2,3 and din 0x0000; io_busy=1 through cycle 4 and 0 from cycle 5; no acks.
- A alone, addr 2, din 0xBEEF, req held 3 cycles from cycle t → cycle t+1: mem_wr=1, addr=2, din=0xBEEF, a_ack=1; cycle t+2: mem_wr=0, no second ack.
- A and B held continuously (A: addr 1, 0x1111; B: addr 3, 0x3333) → grants A,B,A,B on consecutive cycles starting with A; mem_wr=1 every cycle.
- B requests at cycle 1 during INIT → no ack during cycles 1-5; b_ack and the write of B's data appear at cycle 6.
- Reset pulse during alternating traffic → next cycle: acks=0, mem_wr=0, busy=1; INIT restarts at addr 0; first post-init grant goes to A.
- Without REGFILE_ARB_INIT_EN: A req at cycle 1 after reset → a_ack=1 with the write at cycle 2; io_busy stays 0 throughout.
